// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and constants for the instruction fetch stage.
//   XLEN                      datapath width
//   RESET_VECTOR_DEFAULT      default first fetch address
//   EC_INSTR_ADDR_MISALIGNED  exception cause ID attaches to a faulted fetch entry
//   NOP_INSTR                 filler instruction carried by a faulted entry
//   if_state_e                fetch FSM states
//   fetch_entry_t             one instruction buffer entry {exc, pc, instr}
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned     EC_INSTR_ADDR_MISALIGNED = 0;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_DRAIN
    } if_state_e;

    typedef struct packed {
        logic            exc;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: bundle of the fetch stage's external handshakes.
//   redirect_*   PC change request (trap/branch, already prioritised upstream)
//   imem_*       request/response bus to instruction memory (in-order responses)
//   id_pipe_*    IF->ID pipe: head entry valid/pc/instruction/exception plus ready/flush
// Modports: master = fetch stage side, slave = environment (memory, ID, redirect source).
interface if_stage_if;
    import if_stage_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            id_pipe_ready;
    logic            id_pipe_flush;
    logic            id_pipe_valid;
    logic [XLEN-1:0] id_pipe_pc;
    logic [XLEN-1:0] id_pipe_instruction;
    logic            id_pipe_exc_pending;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  id_pipe_ready, id_pipe_flush,
        output imem_req, imem_addr,
        output id_pipe_valid, id_pipe_pc, id_pipe_instruction, id_pipe_exc_pending
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_ready, imem_rvalid, imem_rdata,
        output id_pipe_ready, id_pipe_flush,
        input  imem_req, imem_addr,
        input  id_pipe_valid, id_pipe_pc, id_pipe_instruction, id_pipe_exc_pending
    );

endinterface

// File: rtl/if_stage_fifo.sv
// if_stage_fifo: synchronous FIFO with registered storage and a head read straight from the
// storage array (no combinational path from wdata_i to rdata_o).
//   clk_i, rst_i  clock, synchronous active-high reset
//   clear_i       drop all entries; a push in the same cycle becomes the only entry
//   push_i/wdata_i  write; ignored when full unless a pop happens in the same cycle
//   pop_i         remove head; ignored when empty
//   rdata_o/valid_o  head entry and non-empty flag
//   count_o       number of stored entries
// DEPTH must be a power of two, >= 2.
module if_stage_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    // Push at full is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((32'(cnt_q) != DEPTH) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = PtrW'(push_i);
            cnt_d    = CntW'(push_i);
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            if (push_i) mem_q[0] <= wdata_i;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: RV32 instruction fetch stage. Owns the PC, issues in-order word fetches, buffers
// responses in a small FIFO whose head drives the IF->ID pipe, and applies redirects while
// discarding responses to fetches that became stale.
//   clk, rst  clock, synchronous active-high reset
//   bus       if_stage_if.master: redirect_*, imem_* and id_pipe_* handshakes
// Parameters: RESET_VECTOR, FIFO_DEPTH (power of 2, >= 2), MAX_OUTSTD (1..FIFO_DEPTH).
// Build option: define IF_MISALIGN_EXC_EN to turn a misaligned redirect target into a single
// faulted buffer entry (exc_pending=1, NOP) and halt fetch until the next redirect. Without it
// redirect_pc[1:0] is ignored and id_pipe_exc_pending is tied low.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned     FIFO_DEPTH   = 2,
    parameter int unsigned     MAX_OUTSTD   = 2
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.master bus
);
    localparam int unsigned CntW   = $clog2(MAX_OUTSTD + 1);
    localparam int unsigned FCntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EntryW = $bits(fetch_entry_t);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] outstd_q, outstd_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

    logic            accept, rsp, rsp_keep;
    logic            redirect_misaligned;
    logic            fetch_halted;

    logic             fifo_push, fifo_pop, fifo_valid;
    fetch_entry_t     fifo_wdata, fifo_head;
    logic [FCntW-1:0] fifo_cnt;

    logic [XLEN-1:0]  pcq_head;
    logic             unused_pcq_valid;
    logic [FCntW-1:0] unused_pcq_cnt;

    assign accept   = bus.imem_req & bus.imem_ready;
    assign rsp      = bus.imem_rvalid;
    // Responses still owed to pre-redirect fetches are consumed without touching any queue.
    assign rsp_keep = rsp && (drop_cnt_q == '0);

`ifdef IF_MISALIGN_EXC_EN
    logic halt_q, halt_d;

    assign redirect_misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign fetch_halted        = halt_q;

    always_comb begin
        halt_d = halt_q;
        if (bus.redirect_valid) halt_d = redirect_misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) halt_q <= 1'b0;
        else     halt_q <= halt_d;
    end

    assign bus.id_pipe_exc_pending = fifo_valid & fifo_head.exc;
`else
    logic unused_head_exc;

    assign redirect_misaligned     = 1'b0;
    assign fetch_halted            = 1'b0;
    assign unused_head_exc         = fifo_head.exc;
    assign bus.id_pipe_exc_pending = 1'b0;
`endif

    // Outstanding fetches reserve FIFO slots, so a response can always be pushed.
    assign bus.imem_req = (state_q != S_RESET)
                       && (32'(outstd_q) < MAX_OUTSTD)
                       && ((32'(outstd_q) + 32'(fifo_cnt)) < FIFO_DEPTH)
                       && !bus.redirect_valid
                       && !fetch_halted;
    assign bus.imem_addr = word_align(pc_q);

    always_comb begin
        pc_d       = pc_q;
        outstd_d   = outstd_q + CntW'(accept) - CntW'(rsp);
        drop_cnt_d = drop_cnt_q;
        state_d    = state_q;
        fifo_push  = rsp_keep;
        fifo_wdata = '{exc: 1'b0, pc: pcq_head, instr: bus.imem_rdata};

        if (bus.redirect_valid) begin
            pc_d       = redirect_misaligned ? bus.redirect_pc : word_align(bus.redirect_pc);
            // Every fetch still in flight is stale; one answered this cycle is already gone.
            drop_cnt_d = outstd_q - CntW'(rsp);
            fifo_push  = redirect_misaligned;
            fifo_wdata = '{exc: 1'b1, pc: bus.redirect_pc, instr: NOP_INSTR};
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);
        end

        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: if (bus.redirect_valid && (drop_cnt_d != '0)) state_d = S_DRAIN;
            S_DRAIN: if (drop_cnt_d == '0) state_d = S_FETCH;
            default: state_d = S_RESET;
        endcase
    end

    assign fifo_pop = fifo_valid & (bus.id_pipe_ready | bus.id_pipe_flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_VECTOR;
            outstd_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            outstd_q   <= outstd_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // PCs of live in-flight fetches, paired with responses in order.
    if_stage_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_pc_queue (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (bus.redirect_valid),
        .push_i  (accept),
        .wdata_i (word_align(pc_q)),
        .pop_i   (rsp_keep),
        .rdata_o (pcq_head),
        .valid_o (unused_pcq_valid),
        .count_o (unused_pcq_cnt)
    );

    if_stage_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EntryW)
    ) u_instr_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (bus.redirect_valid),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign bus.id_pipe_valid       = fifo_valid;
    assign bus.id_pipe_pc          = fifo_head.pc;
    assign bus.id_pipe_instruction = fifo_head.instr;

    // A response with nothing outstanding means the memory broke the protocol.
    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) rsp |-> (outstd_q != '0)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage. A small in-order memory model answers each
// accepted fetch one cycle later unless held; outputs are sampled on the falling edge.
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_stage_if bus ();

    if_stage #(
        .RESET_VECTOR (32'h0000_0000),
        .FIFO_DEPTH   (2),
        .MAX_OUTSTD   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        id_ready;
        logic        imem_ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rq[$];
    logic        hold;
    vec_t        tbl[$];

    logic        s_req, s_acc, s_rsp, s_valid, s_exc;
    logic [31:0] s_addr, s_pc, s_instr;
    if_state_e   s_state;
    int          s_drop;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0093;
    endfunction

    function automatic vec_t mk(input logic idr, input logic ir, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.id_ready = idr; v.imem_ready = ir; v.exp_req = er;
        v.exp_addr = ea;  v.exp_valid  = ev; v.exp_pc  = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive the memory response, sample outputs mid-cycle, then update the model.
    task automatic tick();
        bus.imem_rvalid = !hold && (rq.size() != 0);
        bus.imem_rdata  = (rq.size() != 0) ? instr_of(rq[0]) : 32'h0;
        @(negedge clk);
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_acc   = bus.imem_req & bus.imem_ready;
        s_rsp   = bus.imem_rvalid;
        s_valid = bus.id_pipe_valid;
        s_pc    = bus.id_pipe_pc;
        s_instr = bus.id_pipe_instruction;
        s_exc   = bus.id_pipe_exc_pending;
        s_state = dut.state_q;
        s_drop  = int'(dut.drop_cnt_q);
        @(posedge clk);
        #1;
        if (s_rsp) rq.delete(0);
        if (s_acc) rq.push_back(s_addr);
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_ready     = 1'b0;
        bus.id_pipe_ready  = 1'b0;
        bus.id_pipe_flush  = 1'b0;
        hold               = 1'b0;
        rq.delete();
        tick();
        tick();
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_exc", 32'(s_exc), 32'd0);
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
    endtask

    initial begin
        // Streaming, ID backpressure for 6 cycles, then imem_ready low for 4 cycles.
        tbl.push_back(mk(1, 1, 0, 32'h00, 0, 32'h00));  // C0 still in S_RESET
        tbl.push_back(mk(1, 1, 1, 32'h00, 0, 32'h00));
        tbl.push_back(mk(1, 1, 1, 32'h04, 0, 32'h00));
        tbl.push_back(mk(1, 1, 0, 32'h00, 1, 32'h00));  // space reserved by 1 outstd + 1 entry
        tbl.push_back(mk(1, 1, 1, 32'h08, 1, 32'h04));
        tbl.push_back(mk(0, 1, 1, 32'h0C, 0, 32'h00));
        tbl.push_back(mk(0, 1, 0, 32'h00, 1, 32'h08));
        tbl.push_back(mk(0, 1, 0, 32'h00, 1, 32'h08));
        tbl.push_back(mk(0, 1, 0, 32'h00, 1, 32'h08));
        tbl.push_back(mk(0, 1, 0, 32'h00, 1, 32'h08));
        tbl.push_back(mk(0, 1, 0, 32'h00, 1, 32'h08));
        tbl.push_back(mk(1, 1, 0, 32'h00, 1, 32'h08));
        tbl.push_back(mk(1, 1, 1, 32'h10, 1, 32'h0C));
        tbl.push_back(mk(1, 1, 1, 32'h14, 0, 32'h00));
        tbl.push_back(mk(1, 1, 0, 32'h00, 1, 32'h10));
        tbl.push_back(mk(1, 0, 1, 32'h18, 1, 32'h14));
        tbl.push_back(mk(1, 0, 1, 32'h18, 0, 32'h00));
        tbl.push_back(mk(1, 0, 1, 32'h18, 0, 32'h00));
        tbl.push_back(mk(1, 0, 1, 32'h18, 0, 32'h00));
        tbl.push_back(mk(1, 1, 1, 32'h18, 0, 32'h00));
        tbl.push_back(mk(1, 1, 1, 32'h1C, 0, 32'h00));
        tbl.push_back(mk(1, 1, 0, 32'h00, 1, 32'h18));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            bus.id_pipe_ready = tbl[i].id_ready;
            bus.imem_ready    = tbl[i].imem_ready;
            tick();
            if (i == 0) chk("t0_state", 32'(s_state), 32'(S_RESET));
            chk($sformatf("t%0d_req", i), 32'(s_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("t%0d_addr", i), s_addr, tbl[i].exp_addr);
            chk($sformatf("t%0d_valid", i), 32'(s_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("t%0d_pc", i), s_pc, tbl[i].exp_pc);
                chk($sformatf("t%0d_instr", i), s_instr, instr_of(tbl[i].exp_pc));
                chk($sformatf("t%0d_exc", i), 32'(s_exc), 32'd0);
            end
        end

        // Redirect with two fetches outstanding: both responses dropped.
        do_reset();
        hold = 1'b1; bus.imem_ready = 1'b1; bus.id_pipe_ready = 1'b1;
        tick();
        tick(); chk("a_c1_req", 32'(s_req), 32'd1);
        tick(); chk("a_c2_addr", s_addr, 32'h04);
        redirect(32'h100);
        tick(); chk("a_c3_req", 32'(s_req), 32'd0);
        bus.redirect_valid = 1'b0; hold = 1'b0;
        tick(); chk("a_c4_req", 32'(s_req), 32'd0);
        chk("a_c4_state", 32'(s_state), 32'(S_DRAIN));
        chk("a_c4_drop", s_drop, 32'd2);
        chk("a_c4_valid", 32'(s_valid), 32'd0);
        tick(); chk("a_c5_req", 32'(s_req), 32'd1);
        chk("a_c5_addr", s_addr, 32'h100);
        chk("a_c5_valid", 32'(s_valid), 32'd0);
        tick(); chk("a_c6_addr", s_addr, 32'h104);
        chk("a_c6_state", 32'(s_state), 32'(S_FETCH));
        chk("a_c6_valid", 32'(s_valid), 32'd0);
        tick(); chk("a_c7_valid", 32'(s_valid), 32'd1);
        chk("a_c7_pc", s_pc, 32'h100);
        chk("a_c7_instr", s_instr, instr_of(32'h100));

        // Redirect in the same cycle as the only outstanding response.
        do_reset();
        bus.imem_ready = 1'b1; bus.id_pipe_ready = 1'b1;
        tick();
        tick();
        redirect(32'h200);
        tick(); chk("b_c2_req", 32'(s_req), 32'd0);
        bus.redirect_valid = 1'b0;
        tick(); chk("b_c3_req", 32'(s_req), 32'd1);
        chk("b_c3_addr", s_addr, 32'h200);
        chk("b_c3_drop", s_drop, 32'd0);
        chk("b_c3_state", 32'(s_state), 32'(S_FETCH));
        chk("b_c3_valid", 32'(s_valid), 32'd0);
        tick(); chk("b_c4_addr", s_addr, 32'h204);
        chk("b_c4_valid", 32'(s_valid), 32'd0);
        tick(); chk("b_c5_valid", 32'(s_valid), 32'd1);
        chk("b_c5_pc", s_pc, 32'h200);

        // Flush pops only the head; then a redirect clears a buffered entry.
        do_reset();
        bus.imem_ready = 1'b1; bus.id_pipe_ready = 1'b0;
        tick(); tick(); tick();
        tick(); chk("c_c3_pc", s_pc, 32'h00);
        chk("c_c3_req", 32'(s_req), 32'd0);
        bus.id_pipe_flush = 1'b1;
        tick(); chk("c_c4_pc", s_pc, 32'h00);
        bus.id_pipe_flush = 1'b0;
        tick(); chk("c_c5_valid", 32'(s_valid), 32'd1);
        chk("c_c5_pc", s_pc, 32'h04);
        chk("c_c5_addr", s_addr, 32'h08);
        redirect(32'h300);
        tick(); chk("c_c6_req", 32'(s_req), 32'd0);
        bus.redirect_valid = 1'b0;
        tick(); chk("c_c7_valid", 32'(s_valid), 32'd0);
        chk("c_c7_addr", s_addr, 32'h300);
        tick(); chk("c_c8_addr", s_addr, 32'h304);
        tick(); chk("c_c9_pc", s_pc, 32'h300);

        // Reset with buffered state: everything restarts from the reset vector.
        do_reset();
        bus.imem_ready = 1'b1; bus.id_pipe_ready = 1'b1;
        tick(); chk("r_c0_state", 32'(s_state), 32'(S_RESET));
        tick(); chk("r_c1_req", 32'(s_req), 32'd1);
        chk("r_c1_addr", s_addr, 32'h0);

`ifdef IF_MISALIGN_EXC_EN
        do_reset();
        bus.imem_ready = 1'b1; bus.id_pipe_ready = 1'b0;
        tick();
        redirect(32'h102);
        tick(); chk("m_c1_req", 32'(s_req), 32'd0);
        bus.redirect_valid = 1'b0; bus.id_pipe_ready = 1'b1;
        tick(); chk("m_c2_req", 32'(s_req), 32'd0);
        chk("m_c2_valid", 32'(s_valid), 32'd1);
        chk("m_c2_pc", s_pc, 32'h102);
        chk("m_c2_instr", s_instr, 32'h13);
        chk("m_c2_exc", 32'(s_exc), 32'd1);
        tick(); chk("m_c3_req", 32'(s_req), 32'd0);
        chk("m_c3_valid", 32'(s_valid), 32'd0);
        redirect(32'h200);
        tick();
        bus.redirect_valid = 1'b0;
        tick(); chk("m_c5_req", 32'(s_req), 32'd1);
        chk("m_c5_addr", s_addr, 32'h200);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
